// File: rtl/mlp_layer_seq.sv
// mlp_layer_seq: dense layer of N_OUT neurons over N_IN inputs, evaluated one product per cycle on a shared MAC.
module mlp_layer_seq #(
  parameter int N_IN = 9,
  parameter int N_OUT = 9,
  parameter int DW = 33,
  parameter int WW = 33,
  parameter int FRAC = 26,
  parameter int RELU = 1,
  parameter string INIT_FILE = "",
  localparam int DEPTH = N_OUT * (N_IN + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_IN*DW-1:0]     in_vec,
  input  logic                   w_we,
  input  logic [AW-1:0]          w_addr,
  input  logic signed [WW-1:0]   w_data,
  output logic                   busy,
  output logic                   done,
  output logic [N_OUT*DW-1:0]    out_vec
);
  localparam int ACC_W = DW + WW + $clog2(N_IN) + 1;
  localparam int IW = $clog2(N_IN + 1);
  localparam int JW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-DW+2){1'b1}}, {(DW-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [N_IN*DW-1:0] x_q, x_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N_OUT*DW-1:0] sh_q, sh_d, out_q, out_d;
  logic keep_v_q, keep_v_d;
  logic [AW-1:0] keep_a_q, keep_a_d;
  logic signed [WW-1:0] keep_w_q, keep_w_d;
  logic signed [WW-1:0] mem_q [DEPTH];
  logic go, wr_ok, last_i, last_j;
  logic [AW-1:0] rd_addr;
  logic signed [WW-1:0] w_rd;
  logic signed [DW-1:0] xi, y;
  logic signed [DW+WW-1:0] prod;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [ACC_W:0] r, rl;
  initial begin
    for (int k = 0; k < DEPTH; k++) mem_q[k] = '0;
  end
  always_ff @(posedge clk) if (wr_ok) mem_q[w_addr] <= w_data;
  assign go = start && state_q == IDLE;
  assign wr_ok = w_we && state_q == IDLE && int'(w_addr) < DEPTH;
  assign last_i = i_q == IW'(N_IN - 1);
  assign last_j = j_q == JW'(N_OUT - 1);
  assign rd_addr = AW'(int'(j_q) * (N_IN + 1) + int'(i_q));
  assign w_rd = (keep_v_q && rd_addr == keep_a_q) ? keep_w_q : mem_q[rd_addr];
  assign xi = x_q[DW-1:0];
  assign prod = xi * w_rd;
  assign acc_sh = acc_q >>> FRAC;
  assign r = (ACC_W+1)'(acc_sh) + (ACC_W+1)'(w_rd);
  assign rl = (RELU != 0 && r < 0) ? '0 : r;
  assign y = rl > MAXV ? MAXV[DW-1:0] : rl < MINV ? MINV[DW-1:0] : rl[DW-1:0];
  assign out_vec = out_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      x_q <= '0;
      acc_q <= '0;
      sh_q <= '0;
      out_q <= '0;
      keep_v_q <= 1'b0;
      keep_a_q <= '0;
      keep_w_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      x_q <= x_d;
      acc_q <= acc_d;
      sh_q <= sh_d;
      out_q <= out_d;
      keep_v_q <= keep_v_d;
      keep_a_q <= keep_a_d;
      keep_w_q <= keep_w_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? MAC : IDLE) :
              state_q == MAC  ? (last_i ? FIN : MAC) :
              state_q == FIN  ? (last_j ? DONE : MAC) : IDLE;
  end
  always_comb begin
    x_d = go ? in_vec : state_q == MAC ? (x_q >> DW) | (x_q << ((N_IN - 1) * DW)) : x_q;
    acc_d = state_q == MAC ? acc_q + ACC_W'(prod) : '0;
    i_d = state_q == MAC ? (last_i ? IW'(N_IN) : i_q + 1'b1) : '0;
    j_d = state_q == FIN ? (last_j ? '0 : j_q + 1'b1) : state_q == MAC ? j_q : '0;
    sh_d = sh_q;
    for (int k = 0; k < N_OUT; k++)
      if (state_q == FIN && j_q == JW'(k)) sh_d[k*DW +: DW] = y;
    out_d = (state_q == FIN && last_j) ? sh_d : out_q;
    keep_v_d = go ? wr_ok : keep_v_q;
    keep_a_d = go ? w_addr : keep_a_q;
    keep_w_d = go ? mem_q[w_addr] : keep_w_q;
  end
  always_comb begin
    busy = state_q == MAC || state_q == FIN;
    done = state_q == DONE;
  end
endmodule
